// File: rtl/seq_det_pkg.sv
// seq_det_pkg: default sizing, lane config type and length clamp for the multi-pattern detector
package seq_det_pkg;
  localparam int PAT_W = 8;
  localparam int N_PAT = 4;
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int IDX_W = (N_PAT > 1) ? $clog2(N_PAT) : 1;
  typedef struct packed {
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
  } lane_cfg_t;
  function automatic int clamp_len(int len, int pat_w);
    return (len > pat_w) ? pat_w : len;
  endfunction
endpackage

// File: rtl/seq_det_lane.sv
// seq_det_lane: one pattern lane with its config, fill count, compare, hit flag and saturating counter
module seq_det_lane #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample,
  input  logic             overlap,
  input  logic             we,
  input  logic [PAT_W-1:0] hist,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  output logic             flag,
  output logic [CNT_W-1:0] cnt
);
  logic [PAT_W-1:0] pat, mask;
  logic [LEN_W-1:0] len, fill;
  logic hit;
  assign mask = (len == '0) ? '0 : {PAT_W{1'b1}} >> (PAT_W - int'(len));
  // fill >= len-1 means this bit completes len fresh bits; avoids overflow of fill+1
  assign hit = sample && !we && len != '0 && fill >= len - 1'b1 && ((hist ^ pat) & mask) == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pat <= '0;
      len <= '0;
      fill <= '0;
      flag <= 1'b0;
      cnt <= '0;
    end else if (clear) begin
      fill <= '0;
      flag <= 1'b0;
      cnt <= '0;
    end else if (we) begin
      pat <= pat_in;
      len <= len_in;
      fill <= '0;
      flag <= 1'b0;
      cnt <= '0;
    end else begin
      flag <= hit;
      if (sample) fill <= (hit && !overlap) ? '0 : (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
      if (hit && !(&cnt)) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/seq_detector_multi.sv
// seq_detector_multi: serial stream matched against N_PAT programmable patterns with per-lane pulses and counters
module seq_detector_multi #(
  parameter int PAT_W = seq_det_pkg::PAT_W,
  parameter int N_PAT = seq_det_pkg::N_PAT,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1),
  localparam int IDX_W = (N_PAT > 1) ? $clog2(N_PAT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in,
  input  logic                   clear,
  input  logic                   mode_overlap,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [PAT_W-1:0]       cfg_pat,
  input  logic [LEN_W-1:0]       cfg_len,
  output logic [N_PAT-1:0]       flag,
  output logic                   match_any,
  output logic [N_PAT*CNT_W-1:0] hit_cnt
);
  logic [PAT_W-1:0] hist, hist_next;
  logic [LEN_W-1:0] len_in;
  logic sample;
  assign hist_next = PAT_W'({hist, in});
  assign sample = in_valid && !clear;
  assign len_in = LEN_W'(seq_det_pkg::clamp_len(int'(cfg_len), PAT_W));
  always_ff @(posedge clk or negedge reset)
    if (!reset) hist <= '0;
    else if (clear) hist <= '0;
    else if (sample) hist <= hist_next;
  // an index with no matching lane simply selects nothing, so out-of-range writes drop out
  for (genvar k = 0; k < N_PAT; k++) begin : g_lane
    seq_det_lane #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) u_lane (
      .clk(clk),
      .reset(reset),
      .clear(clear),
      .sample(sample),
      .overlap(mode_overlap),
      .we(cfg_we && !clear && cfg_idx == IDX_W'(k)),
      .hist(hist_next),
      .pat_in(cfg_pat),
      .len_in(len_in),
      .flag(flag[k]),
      .cnt(hit_cnt[k*CNT_W +: CNT_W])
    );
  end
  assign match_any = |flag;
endmodule

// File: tb/tb_seq_detector_multi.sv
// tb_seq_detector_multi: directed vector tables plus hand-written corner sequences for seq_detector_multi
module tb_seq_detector_multi;
  logic clk = 0, reset = 1, in_valid = 0, in = 0, clear = 0, mode_overlap = 1, cfg_we = 0;
  logic [1:0] cfg_idx = '0;
  logic [7:0] cfg_pat = '0;
  logic [3:0] cfg_len = '0;
  logic [3:0] flag;
  logic match_any;
  logic [7:0] hit_cnt;
  int compared = 0, mismatched = 0;
  typedef struct {
    logic valid;
    logic b;
    logic mode;
    logic [3:0] flag;
    logic [7:0] cnt;
  } vec_t;
  vec_t vq[$];

  seq_detector_multi #(.PAT_W(8), .N_PAT(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .clear(clear),
    .mode_overlap(mode_overlap), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .flag(flag), .match_any(match_any), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(string name, logic [3:0] ef, logic [7:0] ec);
    chk({name, ".flag"}, 32'(flag), 32'(ef));
    chk({name, ".match_any"}, 32'(match_any), 32'(|ef));
    chk({name, ".hit_cnt"}, 32'(hit_cnt), 32'(ec));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 0;
    cfg_we = 0;
    clear = 0;
  endtask

  task automatic bit_in(logic b);
    in_valid = 1;
    in = b;
    tick();
  endtask

  task automatic cfg_write(int idx, logic [7:0] p, logic [3:0] l);
    cfg_we = 1;
    cfg_idx = 2'(idx);
    cfg_pat = p;
    cfg_len = l;
    tick();
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
  endtask

  function automatic void v(logic valid, logic b, logic mode, logic [3:0] f, logic [7:0] c);
    vq.push_back('{valid, b, mode, f, c});
  endfunction

  task automatic run_vecs(string name);
    foreach (vq[i]) begin
      mode_overlap = vq[i].mode;
      in_valid = vq[i].valid;
      in = vq[i].b;
      tick();
      chk_out($sformatf("%s[%0d]", name, i), vq[i].flag, vq[i].cnt);
    end
    vq.delete();
  endtask

  initial begin
    #1 reset = 0;
    #11 chk_out("reset", 4'h0, 8'h00);
    reset = 1;
    // lane0 = 1011, overlap; second hit reuses the trailing 1 of the first
    cfg_write(0, 8'b1011, 4);
    chk_out("cfg0", 4'h0, 8'h00);
    v(1,1,1,4'h0,8'h00); v(1,0,1,4'h0,8'h00); v(1,1,1,4'h0,8'h00); v(1,1,1,4'h1,8'h01);
    v(0,0,1,4'h0,8'h01); v(1,0,1,4'h0,8'h01); v(1,1,1,4'h0,8'h01); v(1,1,1,4'h1,8'h02);
    run_vecs("basic");
    // lane1 = 111 on five ones: overlap hits bits 3,4,5
    do_clear();
    cfg_write(1, 8'b111, 3);
    v(1,1,1,4'h0,8'h00); v(1,1,1,4'h0,8'h00); v(1,1,1,4'h2,8'h04);
    v(1,1,1,4'h2,8'h08); v(1,1,1,4'h2,8'h0C);
    run_vecs("overlap");
    // non-overlap: one hit in five ones, the sixth completes a fresh run
    do_clear();
    v(1,1,0,4'h0,8'h00); v(1,1,0,4'h0,8'h00); v(1,1,0,4'h2,8'h04);
    v(1,1,0,4'h0,8'h04); v(1,1,0,4'h0,8'h04); v(1,1,0,4'h2,8'h08);
    run_vecs("nonoverlap");
    // lane0 = 10, lane2 = 0110, stream 0110 with gaps
    do_clear();
    cfg_write(0, 8'b10, 2);
    cfg_write(2, 8'b0110, 4);
    v(1,0,1,4'h0,8'h00); v(0,0,1,4'h0,8'h00); v(1,1,1,4'h0,8'h00); v(0,0,1,4'h0,8'h00);
    v(1,1,1,4'h0,8'h00); v(0,0,1,4'h0,8'h00); v(1,0,1,4'h5,8'h11); v(0,0,1,4'h0,8'h11);
    run_vecs("gaps");
    // 2-bit counter saturates at 3
    do_clear();
    cfg_write(0, 8'h01, 1);
    cfg_write(1, 8'h00, 0);
    v(1,1,1,4'h1,8'h01); v(1,1,1,4'h1,8'h02); v(1,1,1,4'h1,8'h03);
    v(1,1,1,4'h1,8'h03); v(1,1,1,4'h1,8'h03); v(1,1,1,4'h1,8'h03);
    run_vecs("saturate");
    // length 15 clamps to 8
    do_clear();
    cfg_write(0, 8'h00, 0);
    cfg_write(3, 8'hFF, 4'd15);
    for (int i = 0; i < 7; i++) v(1,1,1,4'h0,8'h00);
    v(1,1,1,4'h8,8'h40); v(1,1,1,4'h8,8'h80);
    run_vecs("clamp");
    // cfg write on the completing bit suppresses the hit and restarts the fill
    do_clear();
    cfg_write(3, 8'h00, 0);
    cfg_write(0, 8'b1011, 4);
    bit_in(1); bit_in(0); bit_in(1);
    cfg_we = 1; cfg_idx = 0; cfg_pat = 8'b1011; cfg_len = 4;
    bit_in(1);
    chk_out("cfg_pri", 4'h0, 8'h00);
    bit_in(1); bit_in(0); bit_in(1);
    chk_out("cfg_pri_pre", 4'h0, 8'h00);
    bit_in(1);
    chk_out("cfg_pri_hit", 4'h1, 8'h01);
    // clear drops the coincident bit
    do_clear();
    cfg_write(0, 8'h01, 1);
    cfg_write(1, 8'b11, 2);
    clear = 1;
    bit_in(1);
    chk_out("clr_drop", 4'h0, 8'h00);
    bit_in(1);
    chk_out("clr_next", 4'h1, 8'h01);
    bit_in(1);
    chk_out("clr_next2", 4'h3, 8'h06);
    // asynchronous reset while flags are high, then lanes stay disabled
    #2 reset = 0;
    #1 chk_out("async_rst", 4'h0, 8'h00);
    @(negedge clk);
    reset = 1;
    bit_in(1);
    chk_out("rst_dis0", 4'h0, 8'h00);
    bit_in(1);
    chk_out("rst_dis1", 4'h0, 8'h00);
    cfg_write(0, 8'h01, 1);
    bit_in(1);
    chk_out("rst_reprog", 4'h1, 8'h01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
